// File: rtl/comm_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : comm_ctrl_pkg
// Description : Shared definitions for the communication control blocks:
//               one-hot state encodings, the sequencer state type, default
//               timing constants and a small helper for minimum counts.
// Revision    : 1.0 - initial release
// ============================================================================
package comm_ctrl_pkg;

    // Default timing/size constants used by command_sequencer parameters.
    localparam int c_def_n_cmd     = 4;
    localparam int c_def_cmd_w     = 3;
    localparam int c_def_delay_cyc = 100000000;
    localparam int c_def_delay_w   = 28;
    localparam int c_def_hold_cyc  = 2000;
    localparam int c_def_tmo_cyc   = 1000000;

    // One-hot state encodings of the command sequencer.
    localparam int c_st_w = 8;
    localparam logic [c_st_w-1:0] c_st_idle      = 8'b0000_0001;
    localparam logic [c_st_w-1:0] c_st_issue     = 8'b0000_0010;
    localparam logic [c_st_w-1:0] c_st_wait_ack  = 8'b0000_0100;
    localparam logic [c_st_w-1:0] c_st_wait_done = 8'b0000_1000;
    localparam logic [c_st_w-1:0] c_st_delay     = 8'b0001_0000;
    localparam logic [c_st_w-1:0] c_st_wait_comm = 8'b0010_0000;
    localparam logic [c_st_w-1:0] c_st_hold      = 8'b0100_0000;
    localparam logic [c_st_w-1:0] c_st_wait_data = 8'b1000_0000;

    typedef enum logic [c_st_w-1:0] {
        IDLE      = c_st_idle,
        ISSUE     = c_st_issue,
        WAIT_ACK  = c_st_wait_ack,
        WAIT_DONE = c_st_wait_done,
        DELAY     = c_st_delay,
        WAIT_COMM = c_st_wait_comm,
        HOLD      = c_st_hold,
        WAIT_DATA = c_st_wait_data
    } seq_state_t;

    // A programmed duration of zero still occupies one cycle.
    function automatic int at_least_one(input int value);
        return (value < 1) ? 1 : value;
    endfunction

endpackage : comm_ctrl_pkg
`default_nettype wire

// File: rtl/cycle_timer.sv
`default_nettype none
// ============================================================================
// Module      : cycle_timer
// Description : Loadable down-counter. After a load of N (N >= 1) the
//               expired flag is high on the N-th cycle following the load,
//               so a state that exits on expired lasts exactly N cycles.
// Ports       : clk      - clock
//               rst      - asynchronous active-low reset
//               load     - load load_val on the next edge
//               load_val - cycle count to time
//               expired  - count has reached its final cycle
// Revision    : 1.0 - initial release
// ============================================================================
module cycle_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expired
);

    localparam logic [W-1:0] c_one = W'(1);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - c_one;
        end
    end

    assign expired = (r_count <= c_one);

endmodule : cycle_timer
`default_nettype wire

// File: rtl/command_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : command_sequencer
// Description : Issues N_CMD commands to a command engine with a handshake
//               on ready_command and a fixed inter-command delay, then
//               requests the data phase (start_datos) once the link is free,
//               holds it a minimum time and waits for the data engine.
//               Timeout and abort return to IDLE with a sticky err flag.
// Ports       : clk, rst (async active-low)
//               start_in            - begin a sequence (IDLE only)
//               abort               - cancel from any non-IDLE state
//               ready_command       - command engine ready (low = executing)
//               bussyComunicaciones - link busy
//               bussy_e             - data engine busy
//               command_1           - current command index
//               start               - command-phase enable
//               start_datos         - data-phase request
//               busy                - sequencer not IDLE
//               done                - one-cycle completion pulse
//               err                 - sticky timeout/abort flag
//               cmd_cnt             - commands completed this sequence
// Revision    : 1.0 - initial release
// ============================================================================
module command_sequencer
    import comm_ctrl_pkg::*;
#(
    parameter int N_CMD     = c_def_n_cmd,
    parameter int CMD_W     = c_def_cmd_w,
    parameter int DELAY_CYC = c_def_delay_cyc,
    parameter int DELAY_W   = c_def_delay_w,
    parameter int HOLD_CYC  = c_def_hold_cyc,
    parameter int TMO_CYC   = c_def_tmo_cyc
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start_in,
    input  logic           abort,
    input  logic           ready_command,
    input  logic           bussyComunicaciones,
    input  logic           bussy_e,
    output logic [CMD_W-1:0] command_1,
    output logic           start,
    output logic           start_datos,
    output logic           busy,
    output logic           done,
    output logic           err,
    output logic [CMD_W:0] cmd_cnt
);

    // The shared timer must hold both the delay and the hold count.
    localparam int c_hold_w = (HOLD_CYC > 1) ? $clog2(HOLD_CYC + 1) : 1;
    localparam int c_tmr_w  = (DELAY_W > c_hold_w) ? DELAY_W : c_hold_w;
    localparam logic [c_tmr_w-1:0] c_delay_load = c_tmr_w'(at_least_one(DELAY_CYC));
    localparam logic [c_tmr_w-1:0] c_hold_load  = c_tmr_w'(at_least_one(HOLD_CYC));

    // Timeout counter runs 0..TMO_CYC-1 while waiting; the wait ends on the
    // TMO_CYC-th cycle without the awaited edge.
    localparam int c_tmo_w = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;
    localparam logic [c_tmo_w-1:0] c_tmo_last = c_tmo_w'((TMO_CYC > 0) ? TMO_CYC - 1 : 0);

    localparam logic [CMD_W-1:0] c_cmd_last = CMD_W'(N_CMD - 1);
    localparam logic [CMD_W:0]   c_cnt_max  = (CMD_W + 1)'(N_CMD);

    seq_state_t          r_state, w_state;
    logic [CMD_W-1:0]    r_cmd, w_cmd;
    logic [CMD_W:0]      r_cnt, w_cnt;
    logic                r_start, w_start;
    logic                r_start_datos, w_start_datos;
    logic                r_busy, w_busy;
    logic                r_done, w_done;
    logic                r_err, w_err;
    logic [c_tmo_w-1:0]  r_tmo, w_tmo;

    logic                w_tmr_load;
    logic [c_tmr_w-1:0]  w_tmr_val;
    logic                w_tmr_expired;
    logic                w_tmo_hit;

    cycle_timer #(
        .W (c_tmr_w)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (w_tmr_load),
        .load_val (w_tmr_val),
        .expired  (w_tmr_expired)
    );

    assign w_tmo_hit = (TMO_CYC > 0) && (r_tmo == c_tmo_last);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= IDLE;
            r_cmd         <= '0;
            r_cnt         <= '0;
            r_start       <= 1'b0;
            r_start_datos <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_err         <= 1'b0;
            r_tmo         <= '0;
        end else begin
            r_state       <= w_state;
            r_cmd         <= w_cmd;
            r_cnt         <= w_cnt;
            r_start       <= w_start;
            r_start_datos <= w_start_datos;
            r_busy        <= w_busy;
            r_done        <= w_done;
            r_err         <= w_err;
            r_tmo         <= w_tmo;
        end
    end

    always_comb begin
        w_state       = r_state;
        w_cmd         = r_cmd;
        w_cnt         = r_cnt;
        w_start       = r_start;
        w_start_datos = r_start_datos;
        w_done        = 1'b0;
        w_err         = r_err;
        w_tmo         = r_tmo;
        w_tmr_load    = 1'b0;
        w_tmr_val     = c_delay_load;

        // Abort wins over every transition of a legal active state; an
        // illegal encoding falls through to the recovery branch instead.
        if (abort && (r_state != IDLE) && $onehot(r_state)) begin
            w_state       = IDLE;
            w_start       = 1'b0;
            w_start_datos = 1'b0;
            w_err         = 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start_in) begin
                        w_state = ISSUE;
                        w_cmd   = '0;
                        w_cnt   = '0;
                        w_err   = 1'b0;
                        w_start = 1'b1;
                    end
                end
                ISSUE: begin
                    w_state = WAIT_ACK;
                    w_tmo   = '0;
                end
                WAIT_ACK: begin
                    if (!ready_command) begin
                        w_state = WAIT_DONE;
                        w_tmo   = '0;
                    end else if (w_tmo_hit) begin
                        w_state = IDLE;
                        w_start = 1'b0;
                        w_err   = 1'b1;
                    end else begin
                        w_tmo = r_tmo + 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (ready_command) begin
                        w_state    = DELAY;
                        w_tmr_load = 1'b1;
                        w_tmr_val  = c_delay_load;
                        if (r_cnt < c_cnt_max) begin
                            w_cnt = r_cnt + 1'b1;
                        end
                    end else if (w_tmo_hit) begin
                        w_state = IDLE;
                        w_start = 1'b0;
                        w_err   = 1'b1;
                    end else begin
                        w_tmo = r_tmo + 1'b1;
                    end
                end
                DELAY: begin
                    if (w_tmr_expired) begin
                        if (r_cmd < c_cmd_last) begin
                            w_cmd   = r_cmd + 1'b1;
                            w_state = ISSUE;
                        end else begin
                            w_start = 1'b0;
                            w_state = WAIT_COMM;
                        end
                    end
                end
                WAIT_COMM: begin
                    if (!bussyComunicaciones) begin
                        w_state       = HOLD;
                        w_start_datos = 1'b1;
                        w_tmr_load    = 1'b1;
                        w_tmr_val     = c_hold_load;
                    end
                end
                HOLD: begin
                    if (w_tmr_expired) begin
                        w_state = WAIT_DATA;
                    end
                end
                WAIT_DATA: begin
                    if (!bussy_e) begin
                        w_state       = IDLE;
                        w_start_datos = 1'b0;
                        w_done        = 1'b1;
                    end
                end
                default: begin
                    w_state       = IDLE;
                    w_cmd         = '0;
                    w_cnt         = '0;
                    w_start       = 1'b0;
                    w_start_datos = 1'b0;
                    w_err         = 1'b0;
                    w_tmo         = '0;
                end
            endcase
        end

        w_busy = (w_state != IDLE);
    end

    assign command_1   = r_cmd;
    assign cmd_cnt     = r_cnt;
    assign start       = r_start;
    assign start_datos = r_start_datos;
    assign busy        = r_busy;
    assign done        = r_done;
    assign err         = r_err;

endmodule : command_sequencer
`default_nettype wire

// File: doc/command_sequencer.md
COMMAND_SEQUENCER -- requirements
Module: command_sequencer

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-low reset, with ports named clk and rst as elsewhere in the codebase.
REQ-002 The module SHALL have these parameters (name, default, meaning):
- N_CMD, 4, commands per sequence, 1..2**CMD_W.
- CMD_W, 3, command index width.
- DELAY_CYC, 100000000, inter-command delay in cycles.
- DELAY_W, 28, delay counter width, at least clog2(DELAY_CYC+1).
- HOLD_CYC, 2000, minimum start_datos assertion in cycles.
- TMO_CYC, 1000000, handshake timeout in cycles; 0 disables it.
REQ-003 The module SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, clock.
- rst, in, 1, asynchronous active-low reset.
- start_in, in, 1, begin a sequence; sampled only in IDLE.
- abort, in, 1, synchronous cancel; acts in any non-IDLE state.
- ready_command, in, 1, command engine ready; low while a command executes.
- bussyComunicaciones, in, 1, link busy.
- bussy_e, in, 1, data engine busy.
- command_1, out, CMD_W, current command index.
- start, out, 1, command-phase enable.
- start_datos, out, 1, data-phase request.
- busy, out, 1, high in any non-IDLE state.
- done, out, 1, one-cycle pulse on successful completion.
- err, out, 1, sticky timeout/abort flag.
- cmd_cnt, out, CMD_W+1, number of commands completed in the current sequence.

Function
REQ-004 All outputs SHALL be registered; the state encoding SHALL be one-hot with states IDLE, ISSUE, WAIT_ACK, WAIT_DONE, DELAY, WAIT_COMM, HOLD, WAIT_DATA.
REQ-005 In IDLE, start_in=1 SHALL transition to ISSUE on the next edge and, on that edge, set command_1=0, cmd_cnt=0 and err=0.
REQ-006 ISSUE SHALL last 1 cycle with start=1, then go to WAIT_ACK; start SHALL stay 1 from ISSUE of command 0 until the exit from the last DELAY.
REQ-007 WAIT_ACK SHALL wait for ready_command=0, then go to WAIT_DONE; WAIT_DONE SHALL wait for ready_command=1, then go to DELAY and increment cmd_cnt.
REQ-008 The timeout counter SHALL reload on entry to WAIT_ACK and to WAIT_DONE; when TMO_CYC>0 and the counter reaches TMO_CYC cycles without the awaited edge, the FSM SHALL go to IDLE with err=1, start=0 and no done pulse.
REQ-009 DELAY SHALL occupy exactly max(DELAY_CYC,1) cycles.
REQ-010 On DELAY exit, if command_1<N_CMD-1 the FSM SHALL increment command_1 and go to ISSUE; otherwise it SHALL set start=0 and go to WAIT_COMM.
REQ-011 WAIT_COMM SHALL wait for bussyComunicaciones=0, then go to HOLD with start_datos=1.
REQ-012 HOLD SHALL last exactly max(HOLD_CYC,1) cycles regardless of bussyComunicaciones, then go to WAIT_DATA.
REQ-013 WAIT_DATA SHALL keep start_datos=1 until bussy_e is sampled 0, then clear start_datos, pulse done for 1 cycle and return to IDLE.
REQ-014 abort=1 in any non-IDLE state SHALL, on the next edge, clear start and start_datos, set err=1 and go to IDLE; abort SHALL take priority over every other transition in the same cycle.
REQ-015 start_in SHALL be ignored outside IDLE; start_in and abort both high in IDLE SHALL start a sequence.
REQ-016 The command_1 increment SHALL never wrap: the last command issued SHALL be N_CMD-1, and cmd_cnt SHALL saturate at N_CMD.
REQ-017 An unreachable state encoding SHALL recover to IDLE with all outputs at their reset values.

Reset
REQ-018 When rst=0, the module SHALL asynchronously force state=IDLE and set command_1, cmd_cnt, start, start_datos, busy, done and err to 0 and all counters to 0, including when reset asserts mid-sequence.
REQ-019 After rst deasserts, the module SHALL take no action until start_in is sampled 1.

Structure
REQ-020 The state localparams and the default timing constants SHALL reside in the shared package comm_ctrl_pkg.
REQ-021 One sub-module, cycle_timer (load, count value, expired), SHALL be instantiated for both the delay and hold counts; the timeout SHALL use a separate counter.

Verification
REQ-022 The bench SHALL use N_CMD=4, DELAY_CYC=5, HOLD_CYC=3 and TMO_CYC=10, with a well-behaved engine.
REQ-023 Full sequence:
- Stimulus: start_in pulse.
- Required response: command_1 steps 0,1,2,3; start stays high throughout; start_datos stays high for at least 3 cycles; a single done pulse follows; cmd_cnt=4; err=0.
REQ-024 Ack timeout:
- Stimulus: ready_command held at 1 after ISSUE.
- Required response: err=1 and IDLE 10 cycles after entry to WAIT_ACK; start=0; no done pulse.
REQ-025 Abort during DELAY of command 2:
- Stimulus: abort asserted in that DELAY.
- Required response: next cycle start=0, start_datos=0, err=1, busy=0; cmd_cnt=3.
REQ-026 Busy data link:
- Stimulus: bussyComunicaciones held at 1 for 20 cycles, then bussy_e held at 1 for 8 cycles after HOLD.
- Required response: start_datos rises only after the link frees and falls on the cycle after bussy_e drops; done follows.
REQ-027 Reset mid-sequence:
- Stimulus: rst pulled low during WAIT_DONE, then released, then start_in pulsed.
- Required response: all outputs are 0 at once; the following start_in restarts from command_1=0.
